regfile_sb: RTL and testbench

//  Parametrised register file with write-to-read bypass, optional hardwired-zero R0 and per-register

---
 rtl/regfile_sb.sv | 97 +++++++++
 tb/tb_regfile_sb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with write-to-read bypass, optional hardwired-zero R0 and a per-register
// busy scoreboard that raises a combinational hazard for decode.
module regfile_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      rs1,
    input  logic [ADDR_W-1:0]      rs2,
    input  logic [ADDR_W-1:0]      blz_rs1,
    input  logic                   rs1_en,
    input  logic                   rs2_en,
    input  logic                   blz_en,
    output logic [DATA_W-1:0]      rs1_data,
    output logic [DATA_W-1:0]      rs2_data,
    output logic                   rs_less_zero,
    input  logic                   rf_wr,
    input  logic [ADDR_W-1:0]      rd,
    input  logic [DATA_W-1:0]      rf_wdata,
    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_rd,
    input  logic                   flush,
    output logic                   hazard,
    output logic [2**ADDR_W-1:0]   busy_vec
);

    localparam int unsigned NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic              wr_ok;
    logic              set_ok;
    logic              fwd1;
    logic              fwd2;
    logic              fwd_blz;
    logic [DATA_W-1:0] blz_val;

    function automatic logic is_zero(input logic [ADDR_W-1:0] idx);
        return ZERO_REG && (idx == '0);
    endfunction

    // Writes to a hardwired-zero R0 are dropped everywhere, including the bypass path.
    assign wr_ok   = rf_wr && !is_zero(rd);
    assign fwd1    = BYPASS && wr_ok && (rd == rs1);
    assign fwd2    = BYPASS && wr_ok && (rd == rs2);
    assign fwd_blz = BYPASS && wr_ok && (rd == blz_rs1);

    assign rs1_data     = fwd1    ? rf_wdata : regs[rs1];
    assign rs2_data     = fwd2    ? rf_wdata : regs[rs2];
    assign blz_val      = fwd_blz ? rf_wdata : regs[blz_rs1];
    assign rs_less_zero = blz_val[DATA_W-1];

    // A busy source is not a hazard when its producer is writing back this cycle and is forwarded.
    always_comb begin
        hazard = 1'b0;
        if (rs1_en && busy[rs1] && !fwd1)        hazard = 1'b1;
        if (rs2_en && busy[rs2] && !fwd2)        hazard = 1'b1;
        if (blz_en && busy[blz_rs1] && !fwd_blz) hazard = 1'b1;
        if (iss_valid && busy[iss_rd])           hazard = 1'b1;
    end

    assign set_ok = iss_valid && !hazard && !is_zero(iss_rd);

    // Priority flush > set > clear > hold; set applied last so it overrides a same-index clear.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (rf_wr)  busy_nxt[rd]     = 1'b0;
            if (set_ok) busy_nxt[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[rd] <= rf_wdata;
        end
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build, a no-bypass build and a zero-R0 build share stimulus.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rs1, rs2, blz_rs1, rd, iss_rd;
    logic        rs1_en, rs2_en, blz_en, rf_wr, iss_valid, flush;
    logic [15:0] rf_wdata;

    logic [15:0] a_rs1, a_rs2, n_rs1, n_rs2, z_rs1, z_rs2;
    logic        a_lz, n_lz, z_lz, a_hz, n_hz, z_hz;
    logic [15:0] a_busy, n_busy, z_busy;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .blz_rs1(blz_rs1),
        .rs1_en(rs1_en), .rs2_en(rs2_en), .blz_en(blz_en),
        .rs1_data(a_rs1), .rs2_data(a_rs2), .rs_less_zero(a_lz),
        .rf_wr(rf_wr), .rd(rd), .rf_wdata(rf_wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .hazard(a_hz), .busy_vec(a_busy)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .blz_rs1(blz_rs1),
        .rs1_en(rs1_en), .rs2_en(rs2_en), .blz_en(blz_en),
        .rs1_data(n_rs1), .rs2_data(n_rs2), .rs_less_zero(n_lz),
        .rf_wr(rf_wr), .rd(rd), .rf_wdata(rf_wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .hazard(n_hz), .busy_vec(n_busy)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .blz_rs1(blz_rs1),
        .rs1_en(rs1_en), .rs2_en(rs2_en), .blz_en(blz_en),
        .rs1_data(z_rs1), .rs2_data(z_rs2), .rs_less_zero(z_lz),
        .rf_wr(rf_wr), .rd(rd), .rf_wdata(rf_wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .hazard(z_hz), .busy_vec(z_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks land well before the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1 = 4'd0; rs2 = 4'd0; blz_rs1 = 4'd0; rd = 4'd0; iss_rd = 4'd0;
        rs1_en = 1'b0; rs2_en = 1'b0; blz_en = 1'b0;
        rf_wr = 1'b0; iss_valid = 1'b0; flush = 1'b0; rf_wdata = 16'h0000;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        chk("reset_rs1", 32'(a_rs1), 32'h0);
        chk("reset_busy", 32'(a_busy), 32'h0);
        chk("reset_hazard", 32'(a_hz), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Mid-run async reset clears data and busy bits without a clock edge
        rf_wr = 1'b1; rd = 4'd3; rf_wdata = 16'h1234;
        iss_valid = 1'b1; iss_rd = 4'd4;
        step();
        idle();
        rs1 = 4'd3;
        #1;
        chk("pre_rst_r3", 32'(a_rs1), 32'h1234);
        chk("pre_rst_busy", 32'(a_busy), 32'h0010);
        rst_n = 1'b0;
        #1;
        chk("rst_r3", 32'(a_rs1), 32'h0);
        chk("rst_busy", 32'(a_busy), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Write with same-cycle bypass; no-bypass build sees the old value
        rf_wr = 1'b1; rd = 4'd5; rf_wdata = 16'h8001;
        rs1 = 4'd5; rs2 = 4'd5; blz_rs1 = 4'd5;
        #1;
        chk("byp_rs1", 32'(a_rs1), 32'h8001);
        chk("byp_rs2", 32'(a_rs2), 32'h8001);
        chk("byp_lz", 32'(a_lz), 32'h1);
        chk("nb_rs1_old", 32'(n_rs1), 32'h0);
        chk("nb_lz_old", 32'(n_lz), 32'h0);
        step();
        rf_wr = 1'b0;
        #1;
        chk("nb_rs1_new", 32'(n_rs1), 32'h8001);
        chk("nb_lz_new", 32'(n_lz), 32'h1);
        blz_rs1 = 4'd3;
        #1;
        chk("lz_zero_reg", 32'(a_lz), 32'h0);
        idle();

        // RAW hazard resolved by writeback bypass
        iss_valid = 1'b1; iss_rd = 4'd7;
        step();
        idle();
        #1;
        chk("raw_busy_set", 32'(a_busy), 32'h0080);
        rs1 = 4'd7; rs1_en = 1'b1;
        #1;
        chk("raw_hazard", 32'(a_hz), 32'h1);
        rf_wr = 1'b1; rd = 4'd7; rf_wdata = 16'h0042;
        #1;
        chk("raw_hz_byp", 32'(a_hz), 32'h0);
        chk("raw_hz_nobyp", 32'(n_hz), 32'h1);
        chk("raw_data_byp", 32'(a_rs1), 32'h0042);
        step();
        rf_wr = 1'b0;
        #1;
        chk("raw_busy_clr", 32'(a_busy), 32'h0);
        chk("raw_hz_after", 32'(a_hz), 32'h0);
        idle();

        // WAW stall on busy destination blocks the set even while it clears
        iss_valid = 1'b1; iss_rd = 4'd2;
        step();
        idle();
        rf_wr = 1'b1; rd = 4'd2; rf_wdata = 16'h0002;
        iss_valid = 1'b1; iss_rd = 4'd2;
        #1;
        chk("waw_hazard", 32'(a_hz), 32'h1);
        step();
        rf_wr = 1'b0;
        #1;
        chk("waw_no_set", 32'(a_busy), 32'h0);
        chk("waw_hz_gone", 32'(a_hz), 32'h0);
        step();
        idle();
        #1;
        chk("waw_reissue", 32'(a_busy), 32'h0004);
        rf_wr = 1'b1; rd = 4'd2;
        step();
        idle();

        // Set beats clear on a non-busy register
        iss_valid = 1'b1; iss_rd = 4'd8; rf_wr = 1'b1; rd = 4'd8; rf_wdata = 16'h0808;
        #1;
        chk("setclr_hz", 32'(a_hz), 32'h0);
        step();
        idle();
        #1;
        chk("setclr_busy", 32'(a_busy), 32'h0100);
        rf_wr = 1'b1; rd = 4'd8; rf_wdata = 16'h0808;
        step();
        idle();

        // Flush clears all busy bits, ignores issue, still writes data
        iss_valid = 1'b1;
        iss_rd = 4'd1; step();
        iss_rd = 4'd4; step();
        iss_rd = 4'd9; step();
        idle();
        #1;
        chk("pre_flush_busy", 32'(a_busy), 32'h0212);
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 4'd6;
        rf_wr = 1'b1; rd = 4'd10; rf_wdata = 16'hABCD;
        step();
        idle();
        rs1 = 4'd10;
        #1;
        chk("flush_busy", 32'(a_busy), 32'h0);
        chk("flush_wdata", 32'(a_rs1), 32'hABCD);

        // Hardwired zero R0 versus an ordinary R0
        rf_wr = 1'b1; rd = 4'd0; rf_wdata = 16'hFFFF;
        iss_valid = 1'b1; iss_rd = 4'd0;
        rs1 = 4'd0; blz_rs1 = 4'd0; rs1_en = 1'b1; blz_en = 1'b1;
        #1;
        chk("z_rs1_byp", 32'(z_rs1), 32'h0);
        chk("z_lz_byp", 32'(z_lz), 32'h0);
        chk("z_hazard", 32'(z_hz), 32'h0);
        chk("a_r0_byp", 32'(a_rs1), 32'hFFFF);
        step();
        idle();
        rs1 = 4'd0;
        #1;
        chk("z_r0_stored", 32'(z_rs1), 32'h0);
        chk("z_busy0", 32'(z_busy), 32'h0);
        chk("a_r0_stored", 32'(a_rs1), 32'hFFFF);
        chk("a_busy0", 32'(a_busy), 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
